// File: rtl/elbeth_hazard_ctrl.sv
// elbeth_hazard_ctrl: stall/flush sequencing for the ELBETH five-stage pipeline.
// Resolves data-memory wait, EX exception, taken branch, load-use and
// instruction-memory wait by fixed priority. Tracks multi-cycle data-memory
// waits with a timeout watchdog and a one-cycle trap drain, and keeps a
// saturating count of PC-stall cycles.
module elbeth_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_imem_ready,
   input  logic             mem_dmem_req,
   input  logic             mem_dmem_ready,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_branch_taken,
   input  logic             ex_exception,
   output logic             ctrl_pc_stall,
   output logic             ctrl_if_id_stall,
   output logic             ctrl_id_ex_stall,
   output logic             ctrl_ex_mem_stall,
   output logic             ctrl_if_id_flush,
   output logic             ctrl_id_ex_flush,
   output logic             ctrl_ex_mem_flush,
   output logic             ctrl_mem_wb_flush,
   output logic             ctrl_exc_req,
   output logic             ctrl_bus_error,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] ctrl_stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TRAP     = 2'd2,
      ST_UNUSED   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic       w_dmem_wait;
   logic       w_rs1_hit;
   logic       w_rs2_hit;
   logic       w_load_use;

   state_t     w_next_state;
   logic [7:0] w_wait_next;
   logic       w_pc_st;
   logic       w_if_id_st;
   logic       w_id_ex_st;
   logic       w_ex_mem_st;
   logic       w_if_id_fl;
   logic       w_id_ex_fl;
   logic       w_ex_mem_fl;
   logic       w_mem_wb_fl;
   logic       w_exc;
   logic       w_berr;

   // Hazard detection terms evaluated every cycle regardless of state.
   always_comb begin
      w_dmem_wait = mem_dmem_req && !mem_dmem_ready;
      w_rs1_hit   = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
      w_rs2_hit   = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
      w_load_use  = ex_mem_read && (ex_rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit);
   end

   // Priority resolution of hazards and next-state / wait-counter selection.
   always_comb begin
      w_next_state = ST_RUN;
      w_wait_next  = r_wait_cnt;
      w_pc_st      = 1'b0;
      w_if_id_st   = 1'b0;
      w_id_ex_st   = 1'b0;
      w_ex_mem_st  = 1'b0;
      w_if_id_fl   = 1'b0;
      w_id_ex_fl   = 1'b0;
      w_ex_mem_fl  = 1'b0;
      w_mem_wb_fl  = 1'b0;
      w_exc        = 1'b0;
      w_berr       = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (w_dmem_wait) begin
               w_pc_st      = 1'b1;
               w_if_id_st   = 1'b1;
               w_id_ex_st   = 1'b1;
               w_ex_mem_st  = 1'b1;
               w_mem_wb_fl  = 1'b1;
               w_next_state = ST_MEM_WAIT;
               w_wait_next  = 8'd1;
            end else if (ex_exception) begin
               w_exc        = 1'b1;
               w_if_id_fl   = 1'b1;
               w_id_ex_fl   = 1'b1;
               w_ex_mem_fl  = 1'b1;
               w_next_state = ST_TRAP;
            end else if (ex_branch_taken) begin
               w_if_id_fl   = 1'b1;
               w_id_ex_fl   = 1'b1;
            end else if (w_load_use) begin
               w_pc_st      = 1'b1;
               w_if_id_st   = 1'b1;
               w_id_ex_fl   = 1'b1;
            end else if (!if_imem_ready) begin
               w_pc_st      = 1'b1;
               w_if_id_fl   = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            // EX is frozen here, so exception/branch are picked up again in RUN.
            if (mem_dmem_ready) begin
               w_next_state = ST_RUN;
            end else if (r_wait_cnt == TIMEOUT_VAL) begin
               w_berr       = 1'b1;
               w_exc        = 1'b1;
               w_if_id_fl   = 1'b1;
               w_id_ex_fl   = 1'b1;
               w_ex_mem_fl  = 1'b1;
               w_mem_wb_fl  = 1'b1;
               w_next_state = ST_TRAP;
            end else begin
               w_pc_st      = 1'b1;
               w_if_id_st   = 1'b1;
               w_id_ex_st   = 1'b1;
               w_ex_mem_st  = 1'b1;
               w_mem_wb_fl  = 1'b1;
               w_wait_next  = r_wait_cnt + 8'd1;
               w_next_state = ST_MEM_WAIT;
            end
         end

         ST_TRAP: begin
            // Kill the fetch that was issued under the pre-trap PC.
            w_if_id_fl   = 1'b1;
            w_id_ex_fl   = 1'b1;
            w_wait_next  = 8'd0;
            w_next_state = ST_RUN;
         end

         default: begin
            w_next_state = ST_RUN;
         end
      endcase
   end

   // Reset forces a full flush with no stalls or pulses, independent of state.
   always_comb begin
      ctrl_pc_stall     = rst & w_pc_st;
      ctrl_if_id_stall  = rst & w_if_id_st;
      ctrl_id_ex_stall  = rst & w_id_ex_st;
      ctrl_ex_mem_stall = rst & w_ex_mem_st;
      ctrl_if_id_flush  = !rst | w_if_id_fl;
      ctrl_id_ex_flush  = !rst | w_id_ex_fl;
      ctrl_ex_mem_flush = !rst | w_ex_mem_fl;
      ctrl_mem_wb_flush = !rst | w_mem_wb_fl;
      ctrl_exc_req      = rst & w_exc;
      ctrl_bus_error    = rst & w_berr;
      ctrl_state        = rst ? r_state : 2'd0;
      ctrl_stall_cycles = r_stall_cnt;
   end

   // State, wait counter and saturating stall-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_wait_next;
         if (w_pc_st && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Scoreboard bench for elbeth_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Driver applies directed vectors just after each rising edge and queues the
// hand-computed response; the monitor pops and compares at the falling edge.
module tb_elbeth_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       if_imem_ready, mem_dmem_req, mem_dmem_ready;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_exception;
   logic       ctrl_pc_stall, ctrl_if_id_stall, ctrl_id_ex_stall, ctrl_ex_mem_stall;
   logic       ctrl_if_id_flush, ctrl_id_ex_flush, ctrl_ex_mem_flush, ctrl_mem_wb_flush;
   logic       ctrl_exc_req, ctrl_bus_error;
   logic [1:0] ctrl_state;
   logic [3:0] ctrl_stall_cycles;

   elbeth_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .if_imem_ready(if_imem_ready), .mem_dmem_req(mem_dmem_req), .mem_dmem_ready(mem_dmem_ready),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .ex_branch_taken(ex_branch_taken), .ex_exception(ex_exception),
      .ctrl_pc_stall(ctrl_pc_stall), .ctrl_if_id_stall(ctrl_if_id_stall),
      .ctrl_id_ex_stall(ctrl_id_ex_stall), .ctrl_ex_mem_stall(ctrl_ex_mem_stall),
      .ctrl_if_id_flush(ctrl_if_id_flush), .ctrl_id_ex_flush(ctrl_id_ex_flush),
      .ctrl_ex_mem_flush(ctrl_ex_mem_flush), .ctrl_mem_wb_flush(ctrl_mem_wb_flush),
      .ctrl_exc_req(ctrl_exc_req), .ctrl_bus_error(ctrl_bus_error),
      .ctrl_state(ctrl_state), .ctrl_stall_cycles(ctrl_stall_cycles)
   );

   always #5 clk = ~clk;

   // Control bit order: {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, exmem_fl, memwb_fl, exc, berr}
   localparam logic [9:0] C_NONE   = 10'b0000_0000_00;
   localparam logic [9:0] C_RESET  = 10'b0000_1111_00;
   localparam logic [9:0] C_FREEZE = 10'b1111_0001_00;
   localparam logic [9:0] C_EXC    = 10'b0000_1110_10;
   localparam logic [9:0] C_BR     = 10'b0000_1100_00;
   localparam logic [9:0] C_LU     = 10'b1100_0100_00;
   localparam logic [9:0] C_IMISS  = 10'b1000_1000_00;
   localparam logic [9:0] C_TMO    = 10'b0000_1111_11;
   localparam logic [9:0] C_TRAP   = 10'b0000_1100_00;

   typedef struct {
      logic [9:0] ctl;
      logic [1:0] st;
      logic [3:0] cnt;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   vec_id   = 0;

   task automatic drv(input logic r, input logic imr, input logic dq, input logic dr,
                      input logic ex, input logic br, input logic ld,
                      input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [9:0] ctl, input logic [1:0] st, input logic [3:0] cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; if_imem_ready = imr; mem_dmem_req = dq; mem_dmem_ready = dr;
      ex_exception = ex; ex_branch_taken = br; ex_mem_read = ld; ex_rd_addr = rd;
      id_rs1_addr = r1; id_uses_rs1 = u1; id_rs2_addr = r2; id_uses_rs2 = u2;
      e.ctl = ctl; e.st = st; e.cnt = cnt; e.id = vec_id;
      exp_q.push_back(e);
      vec_id++;
   endtask

   task automatic idle(input logic [3:0] cnt);
      drv(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NONE, 2'd0, cnt);
   endtask

   task automatic dwait(input logic rdy, input logic ex, input logic [9:0] ctl,
                        input logic [1:0] st, input logic [3:0] cnt);
      drv(1, 1, 1, rdy, ex, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ctl, st, cnt);
   endtask

   task automatic rand_reset(input logic [3:0] cnt);
      drv(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), C_RESET, 2'd0, cnt);
   endtask

   // Monitor: compare the queued expectation against the DUT mid-cycle.
   initial begin
      exp_t e;
      logic [9:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {ctrl_pc_stall, ctrl_if_id_stall, ctrl_id_ex_stall, ctrl_ex_mem_stall,
                   ctrl_if_id_flush, ctrl_id_ex_flush, ctrl_ex_mem_flush, ctrl_mem_wb_flush,
                   ctrl_exc_req, ctrl_bus_error};
            n_checks++;
            if (act === e.ctl) n_pass++;
            else $display("FAIL vec%0d ctl: got %b expected %b", e.id, act, e.ctl);
            n_checks++;
            if (ctrl_state === e.st) n_pass++;
            else $display("FAIL vec%0d state: got %0d expected %0d", e.id, ctrl_state, e.st);
            n_checks++;
            if (ctrl_stall_cycles === e.cnt) n_pass++;
            else $display("FAIL vec%0d stall_cycles: got %0d expected %0d", e.id, ctrl_stall_cycles, e.cnt);
         end
      end
   end

   initial begin
      rst = 0; if_imem_ready = 1; mem_dmem_req = 0; mem_dmem_ready = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_mem_read = 0; ex_rd_addr = 0; ex_branch_taken = 0; ex_exception = 0;

      // Reset held two cycles with random inputs
      rand_reset(4'd0);
      rand_reset(4'd0);
      idle(4'd0);
      // Load-use on rs2, then rd=0 (no hazard), rs1 hit, rs1 unused
      drv(1, 1, 0, 0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, C_LU, 2'd0, 4'd0);
      idle(4'd1);
      drv(1, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 0, 5'd0, 1, C_NONE, 2'd0, 4'd1);
      drv(1, 1, 0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd7, 0, C_LU, 2'd0, 4'd1);
      drv(1, 1, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd3, 1, C_NONE, 2'd0, 4'd2);
      // Branch with imem miss, imem miss alone, branch beats load-use
      drv(1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_BR, 2'd0, 4'd2);
      drv(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IMISS, 2'd0, 4'd2);
      drv(1, 1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_BR, 2'd0, 4'd3);
      // Exception, then TRAP ignoring a load-use and imem miss
      drv(1, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_EXC, 2'd0, 4'd3);
      drv(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_TRAP, 2'd2, 4'd3);
      idle(4'd3);
      // Memory wait of 3 cycles with exception pending throughout
      dwait(0, 1, C_FREEZE, 2'd0, 4'd3);
      drv(1, 1, 1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FREEZE, 2'd1, 4'd4);
      dwait(0, 1, C_FREEZE, 2'd1, 4'd5);
      dwait(1, 1, C_NONE, 2'd1, 4'd6);
      drv(1, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_EXC, 2'd0, 4'd6);
      idle_trap: drv(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_TRAP, 2'd2, 4'd6);
      // Timeout: fires when wait_cnt reaches 4, then one TRAP cycle
      dwait(0, 0, C_FREEZE, 2'd0, 4'd6);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd7);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd8);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd9);
      dwait(0, 0, C_TMO, 2'd1, 4'd10);
      dwait(0, 0, C_TRAP, 2'd2, 4'd10);
      idle(4'd10);
      // Counter saturation at 15 via repeated imem misses
      for (int i = 0; i < 7; i++) begin
         drv(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IMISS, 2'd0,
             (i >= 5) ? 4'd15 : 4'(10 + i));
      end
      idle(4'd15);
      // Reset mid-wait aborts with no pulse and clears the counter
      dwait(0, 0, C_FREEZE, 2'd0, 4'd15);
      drv(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RESET, 2'd0, 4'd15);
      idle(4'd0);
      // Reset during TRAP
      drv(1, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_EXC, 2'd0, 4'd0);
      drv(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RESET, 2'd0, 4'd0);
      idle(4'd0);
      // Ready arriving exactly when wait_cnt equals the timeout wins
      dwait(0, 0, C_FREEZE, 2'd0, 4'd0);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd1);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd2);
      dwait(0, 0, C_FREEZE, 2'd1, 4'd3);
      dwait(1, 0, C_NONE, 2'd1, 4'd4);
      idle(4'd4);

      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
